// File: rtl/qmult_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qmult_seq_pkg
//  Description : Shared fixed-point definitions for the q* arithmetic blocks.
//                Holds the default word format and the sequential
//                multiplier state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package qmult_seq_pkg;

    // Default word format: 32-bit sign-magnitude with 15 fractional bits
    localparam int C_QMULT_Q = 15;
    localparam int C_QMULT_N = 32;

    // Sequential multiplier control states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } qmult_state_e;

endpackage : qmult_seq_pkg
`default_nettype wire

// File: rtl/qmult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : qmult_seq
//  Description : Sequential sign-magnitude fixed-point multiplier. One
//                shift-and-add step per cycle over the N-1 magnitude bits,
//                truncating result, overflow flag, no saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module qmult_seq
    import qmult_seq_pkg::*;
#(
    parameter int Q = C_QMULT_Q,
    parameter int N = C_QMULT_N
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_multiplicand,
    input  logic [N-1:0] i_multiplier,
    input  logic         i_start,
    output logic [N-1:0] o_result_out,
    output logic         o_complete,
    output logic         o_overflow
);

    localparam int C_MW = N - 1;          // magnitude width
    localparam int C_AW = 2 * N - 2;      // full product width
    localparam int C_CW = $clog2(N);      // iteration counter width
    localparam logic [C_CW-1:0] C_CNT_LOAD = C_CW'(N - 2);

    qmult_state_e       r_state;
    qmult_state_e       w_state_next;
    logic               w_load;
    logic               w_finish;

    logic [C_AW-1:0]    r_mcand;          // multiplicand, shifted left each step
    logic [C_MW-1:0]    r_mplier;         // multiplier, shifted right each step
    logic               r_sign;
    logic [C_AW-1:0]    r_acc;
    logic [C_CW-1:0]    r_cnt;
    logic [N-1:0]       r_result;
    logic               r_ovf;

    logic [C_AW-1:0]    w_addend;
    logic [C_AW-1:0]    w_acc_next;
    logic [C_MW-1:0]    w_mag;
    logic               w_ovf;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start accepted only in IDLE, finish when counter hits 0
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_finish     = 1'b0;
        o_complete   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_complete = 1'b1;
                if (i_start) begin
                    w_state_next = ST_BUSY;
                    w_load       = 1'b1;
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                    w_finish     = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Single adder: accumulate the shifted multiplicand when the current
    // multiplier bit is set; the final sum feeds the result directly.
    always_comb begin
        w_addend   = r_mplier[0] ? r_mcand : '0;
        w_acc_next = r_acc + w_addend;
        w_mag      = w_acc_next[N-2+Q:Q];
        w_ovf      = |w_acc_next[C_AW-1:N-1+Q];
    end

    // Datapath registers: capture on start, iterate while busy, publish at end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_sign   <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_ovf    <= 1'b0;
        end else if (w_load) begin
            r_mcand  <= {{(C_AW-C_MW){1'b0}}, i_multiplicand[N-2:0]};
            r_mplier <= i_multiplier[N-2:0];
            r_sign   <= i_multiplicand[N-1] ^ i_multiplier[N-1];
            r_acc    <= '0;
            r_cnt    <= C_CNT_LOAD;
        end else if (r_state == ST_BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_finish) begin
                // A zero magnitude is always reported as positive zero
                r_result <= {r_sign & (|w_mag), w_mag};
                r_ovf    <= w_ovf;
            end
        end
    end

    // Registered outputs, held stable through IDLE
    always_comb begin
        o_result_out = r_result;
        o_overflow   = r_ovf;
    end

endmodule : qmult_seq
`default_nettype wire

// File: tb/tb_qmult_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_qmult_seq
//  Description : Directed self-checking bench for qmult_seq (N=32, Q=15).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_qmult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic [31:0] result_out;
    logic        complete;
    logic        overflow;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    qmult_seq #(.Q(15), .N(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_multiplicand (multiplicand),
        .i_multiplier   (multiplier),
        .i_start        (start),
        .o_result_out   (result_out),
        .o_complete     (complete),
        .o_overflow     (overflow)
    );

    // Directed vectors with hand-computed products
    localparam int NV = 12;
    logic [31:0] va   [NV] = '{32'h0000C000, 32'h8000C000, 32'h00008000, 32'h80010000,
                               32'h80004000, 32'h00000001, 32'h80000001, 32'h7FFFFFFF,
                               32'h40000000, 32'hC0000000, 32'h00000003, 32'h80000003};
    logic [31:0] vb   [NV] = '{32'h00010000, 32'h00010000, 32'h80008000, 32'h80006000,
                               32'h00000000, 32'h00004000, 32'h00004000, 32'h7FFFFFFF,
                               32'h00008000, 32'h00010000, 32'h00006000, 32'h00006000};
    logic [31:0] vres [NV] = '{32'h00018000, 32'h80018000, 32'h80008000, 32'h0000C000,
                               32'h00000000, 32'h00000000, 32'h00000000, 32'h7FFE0000,
                               32'h40000000, 32'h00000000, 32'h00000002, 32'h80000002};
    logic        vovf [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Start one operation and count cycles with complete low (stimulus only)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ovf,
                          output int busy, output bit tmo);
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        busy  = 0;
        while (complete !== 1'b1 && busy < 100) begin
            busy++;
            @(posedge clk); #1;
        end
        tmo = (busy >= 100);
        res = result_out;
        ovf = overflow;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; multiplicand = '0; multiplier = '0;
        #2;
        n_cmp++; if (complete !== 1'b1)  begin n_bad++; $display("FAIL reset_complete: got %b expected 1", complete); end
        n_cmp++; if (result_out !== '0)  begin n_bad++; $display("FAIL reset_result: got %h expected 00000000", result_out); end
        n_cmp++; if (overflow !== 1'b0)  begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (complete !== 1'b1)  begin n_bad++; $display("FAIL post_reset_idle: got %b expected 1", complete); end
    endtask

    task automatic test_vectors();
        logic [31:0] res; logic ovf; int busy; bit tmo;
        for (int i = 0; i < NV; i++) begin
            run_op(va[i], vb[i], res, ovf, busy, tmo);
            n_cmp++; if (tmo)           begin n_bad++; $display("FAIL vec%0d timeout: busy %0d cycles", i, busy); end
            n_cmp++; if (busy != 31)    begin n_bad++; $display("FAIL vec%0d busy_cycles: got %0d expected 31", i, busy); end
            n_cmp++; if (res !== vres[i]) begin n_bad++; $display("FAIL vec%0d result: got %h expected %h", i, res, vres[i]); end
            n_cmp++; if (ovf !== vovf[i]) begin n_bad++; $display("FAIL vec%0d overflow: got %b expected %b", i, ovf, vovf[i]); end
            // Outputs must hold through idle cycles
            repeat (3) @(posedge clk); #1;
            n_cmp++; if (result_out !== vres[i] || complete !== 1'b1)
                begin n_bad++; $display("FAIL vec%0d hold: got %h/%b expected %h/1", i, result_out, complete, vres[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res; logic ovf; int busy; bit tmo;
        run_op(32'h0000C000, 32'h00010000, res, ovf, busy, tmo);
        n_cmp++; if (tmo || res !== 32'h00018000) begin n_bad++; $display("FAIL b2b_first: got %h expected 00018000", res); end
        run_op(32'h80010000, 32'h80006000, res, ovf, busy, tmo);
        n_cmp++; if (busy != 31) begin n_bad++; $display("FAIL b2b_busy: got %0d expected 31", busy); end
        n_cmp++; if (res !== 32'h0000C000) begin n_bad++; $display("FAIL b2b_second: got %h expected 0000C000", res); end
    endtask

    task automatic test_ignore_busy();
        int busy;
        @(negedge clk);
        multiplicand = 32'h0000C000; multiplier = 32'h00010000; start = 1'b1;
        @(posedge clk); #1;
        busy = 0;
        while (complete !== 1'b1 && busy < 100) begin
            busy++;
            start        = (busy == 31) ? 1'b1 : busy[0];
            multiplicand = $urandom;
            multiplier   = $urandom;
            @(posedge clk); #1;
        end
        start = 1'b0;
        n_cmp++; if (busy != 31) begin n_bad++; $display("FAIL ignore_busy_cycles: got %0d expected 31", busy); end
        n_cmp++; if (result_out !== 32'h00018000) begin n_bad++; $display("FAIL ignore_result: got %h expected 00018000", result_out); end
        @(posedge clk); #1;
        n_cmp++; if (complete !== 1'b1) begin n_bad++; $display("FAIL coincident_start: complete got %b expected 1", complete); end
    endtask

    task automatic test_reset_midbusy();
        logic [31:0] res; logic ovf; int busy; bit tmo;
        @(negedge clk);
        multiplicand = 32'h7FFFFFFF; multiplier = 32'h7FFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (complete !== 1'b0) begin n_bad++; $display("FAIL midbusy_state: complete got %b expected 0", complete); end
        @(negedge clk);
        rst = 1'b1; multiplicand = 32'h12345678; multiplier = 32'h0FEDCBA9; start = 1'b1;
        #1;
        n_cmp++; if (complete !== 1'b1)   begin n_bad++; $display("FAIL async_reset_complete: got %b expected 1", complete); end
        n_cmp++; if (result_out !== '0)   begin n_bad++; $display("FAIL async_reset_result: got %h expected 00000000", result_out); end
        n_cmp++; if (overflow !== 1'b0)   begin n_bad++; $display("FAIL async_reset_overflow: got %b expected 0", overflow); end
        @(posedge clk);
        @(negedge clk); rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk); #1;
        n_cmp++; if (complete !== 1'b1 || result_out !== '0)
            begin n_bad++; $display("FAIL aborted_no_result: got %h/%b expected 00000000/1", result_out, complete); end
        run_op(32'h80010000, 32'h80006000, res, ovf, busy, tmo);
        n_cmp++; if (busy != 31) begin n_bad++; $display("FAIL after_reset_busy: got %0d expected 31", busy); end
        n_cmp++; if (res !== 32'h0000C000 || ovf !== 1'b0)
            begin n_bad++; $display("FAIL after_reset_result: got %h/%b expected 0000C000/0", res, ovf); end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_ignore_busy();
        test_reset_midbusy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_qmult_seq
`default_nettype wire
